// File: rtl/jt900h_idxaddr.sv
// jt900h_idxaddr: indexed memory addresser for the TLCS-900H core.
// Decodes the memory-operand addressing byte, pulls any extra operand bytes
// from the instruction stream, steers the register-file read selectors and
// post-inc / pre-dec strobes, and forms the 24-bit effective address.
//
// Optional build macro: JT900H_IDXADDR_CHK_EN
//   defined   -> adds output 'bad'; reserved modes, unknown sub-mode bytes
//                and step code 3 abort the operand with idx_ok=1, bad=1,
//                idx_addr=0 and no register update.
//   undefined -> reserved modes decode as (#8), step code 3 behaves as 1.
module jt900h_idxaddr (
  input  logic        clk,
  input  logic        rst,
  input  logic        cen,
  input  logic        start,
  input  logic [7:0]  mode_byte,
  output logic        fetch,
  input  logic [7:0]  fbyte,
  input  logic        fbyte_ok,
  output logic [7:0]  idx_rdreg_sel,
  output logic [7:0]  idx_rdreg_aux,
  output logic [1:0]  reg_step,
  output logic        reg_inc,
  output logic        reg_dec,
  input  logic [31:0] rdreg_base,
  input  logic [31:0] rdreg_aux,
  output logic        busy,
  output logic [23:0] idx_addr,
  output logic        idx_ok,
  output logic [1:0]  opsize
`ifdef JT900H_IDXADDR_CHK_EN
  ,
  output logic        bad
`endif
);

`ifdef JT900H_IDXADDR_CHK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_SUB, S_SUBB, S_SUBI, S_REG, S_DISP, S_CALC, S_DONE
  } st_t;

  // How the effective address is formed once all bytes are in
  typedef enum logic [2:0] {
    K_R, K_RD8, K_RD16, K_ABS, K_RR8, K_RR16, K_DEC, K_INC
  } kind_t;

  st_t         st, st_nxt;
  kind_t       kind;
  logic [1:0]  need, cnt;
  logic [23:0] disp;
  logic [7:0]  sel, aux;
  logic [1:0]  step;
  logic        bad_q;
  logic        pend;
  logic [7:0]  pend_mode;
  logic [23:0] calc_addr;

  // A start seen during DONE is parked in pend and launched from IDLE
  logic       go;
  logic [7:0] gmode;
  assign go    = start | pend;
  assign gmode = pend ? pend_mode : mode_byte;

  function automatic logic [7:0] short_code(input logic [2:0] rrr);
    return {(rrr[2] ? 4'hF : 4'hE), rrr[1:0], 2'b00};
  endfunction

  // First-byte decode: address kind, bytes to collect, base selector
  kind_t      dec_kind;
  logic [1:0] dec_need;
  logic [7:0] dec_sel;
  st_t        dec_st;
  logic       dec_abort;
  always_comb begin
    dec_kind  = K_ABS;
    dec_need  = 2'd1;
    dec_sel   = 8'h00;
    dec_st    = S_DISP;
    dec_abort = 1'b0;
    if (!gmode[6]) begin
      dec_sel = short_code(gmode[2:0]);
      if (gmode[3]) begin
        dec_kind = K_RD8;
        dec_st   = S_DISP;
      end else begin
        dec_kind = K_R;
        dec_st   = S_CALC;
      end
    end else begin
      case (gmode[3:0])
        4'h0: dec_need = 2'd1;
        4'h1: dec_need = 2'd2;
        4'h2: dec_need = 2'd3;
        4'h3: dec_st   = S_SUB;
        4'h4: begin dec_kind = K_DEC; dec_st = S_REG; end
        4'h5: begin dec_kind = K_INC; dec_st = S_REG; end
        default: if (CHK) begin dec_abort = 1'b1; dec_st = S_DONE; end
      endcase
    end
  end

  // Long-register sub-mode decode of the byte following 11zz0011
  kind_t      sub_kind;
  logic [1:0] sub_need;
  st_t        sub_st;
  logic       sub_abort;
  logic       reg_abort;
  always_comb begin
    sub_kind  = K_R;
    sub_need  = 2'd0;
    sub_st    = S_CALC;
    sub_abort = 1'b0;
    if (fbyte[1:0] == 2'b01) begin
      sub_kind = K_RD16;
      sub_need = 2'd2;
      sub_st   = S_DISP;
    end else if (fbyte == 8'h03) begin
      sub_kind = K_RR8;
      sub_st   = S_SUBB;
    end else if (fbyte == 8'h07) begin
      sub_kind = K_RR16;
      sub_st   = S_SUBB;
    end else if (fbyte[1:0] != 2'b00 && CHK) begin
      sub_abort = 1'b1;
      sub_st    = S_DONE;
    end
  end
  assign reg_abort = CHK && (fbyte[1:0] == 2'b11);

  // Effective address from the register-file values and collected bytes
  always_comb begin
    calc_addr = rdreg_base[23:0];
    case (kind)
      K_RD8:  calc_addr = rdreg_base[23:0] + {{16{disp[7]}}, disp[7:0]};
      K_RD16: calc_addr = rdreg_base[23:0] + {{8{disp[15]}}, disp[15:0]};
      K_ABS:  calc_addr = disp;
      K_RR8:  calc_addr = rdreg_base[23:0] + {{16{rdreg_aux[7]}}, rdreg_aux[7:0]};
      K_RR16: calc_addr = rdreg_base[23:0] + {{8{rdreg_aux[15]}}, rdreg_aux[15:0]};
      K_DEC:  calc_addr = rdreg_aux[23:0];
      default: calc_addr = rdreg_base[23:0];
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      st <= S_IDLE;
    else if (cen) st <= st_nxt;
  end

  // Next state and byte request; a missing fbyte_ok simply holds the state
  always_comb begin
    st_nxt = st;
    fetch  = 1'b0;
    case (st)
      S_IDLE: if (go) st_nxt = dec_st;
      S_SUB: begin
        fetch = 1'b1;
        if (fbyte_ok) st_nxt = sub_st;
      end
      S_SUBB: begin
        fetch = 1'b1;
        if (fbyte_ok) st_nxt = S_SUBI;
      end
      S_SUBI: begin
        fetch = 1'b1;
        if (fbyte_ok) st_nxt = S_CALC;
      end
      S_REG: begin
        fetch = 1'b1;
        if (fbyte_ok) st_nxt = reg_abort ? S_DONE : S_CALC;
      end
      S_DISP: begin
        fetch = 1'b1;
        if (fbyte_ok && cnt == need - 2'd1) st_nxt = S_CALC;
      end
      S_CALC: st_nxt = S_DONE;
      S_DONE: st_nxt = S_IDLE;
      default: st_nxt = S_IDLE;
    endcase
  end

  // Operand datapath: latch decode results, selectors, bytes and address
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kind      <= K_R;
      need      <= 2'd0;
      cnt       <= 2'd0;
      disp      <= 24'd0;
      sel       <= 8'h00;
      aux       <= 8'h00;
      step      <= 2'd0;
      bad_q     <= 1'b0;
      pend      <= 1'b0;
      pend_mode <= 8'h00;
      opsize    <= 2'd0;
      idx_addr  <= 24'd0;
    end else if (cen) begin
      case (st)
        S_IDLE: if (go) begin
          pend   <= 1'b0;
          opsize <= gmode[5:4];
          kind   <= dec_kind;
          need   <= dec_need;
          cnt    <= 2'd0;
          disp   <= 24'd0;
          sel    <= dec_sel;
          aux    <= dec_sel;
          step   <= 2'd0;
          bad_q  <= dec_abort;
          if (dec_abort) idx_addr <= 24'd0;
        end
        S_SUB: if (fbyte_ok) begin
          kind  <= sub_kind;
          need  <= sub_need;
          sel   <= fbyte & 8'hFC;
          aux   <= fbyte & 8'hFC;
          bad_q <= sub_abort;
          if (sub_abort) idx_addr <= 24'd0;
        end
        S_SUBB: if (fbyte_ok) sel <= fbyte & 8'hFC;
        // Index keeps its full code so byte/word registers are addressable
        S_SUBI: if (fbyte_ok) aux <= fbyte;
        S_REG: if (fbyte_ok) begin
          sel  <= fbyte & 8'hFC;
          aux  <= fbyte & 8'hFC;
          step <= (fbyte[1:0] == 2'b11) ? 2'd1 : fbyte[1:0];
          if (reg_abort) begin
            bad_q    <= 1'b1;
            idx_addr <= 24'd0;
          end
        end
        S_DISP: if (fbyte_ok) begin
          disp[{cnt, 3'b000} +: 8] <= fbyte;
          cnt <= cnt + 2'd1;
        end
        S_CALC: idx_addr <= calc_addr;
        S_DONE: if (start) begin
          pend      <= 1'b1;
          pend_mode <= mode_byte;
        end
        default: ;
      endcase
    end
  end

  assign idx_rdreg_sel = sel;
  assign idx_rdreg_aux = aux;
  assign reg_step      = step;
  assign busy          = (st != S_IDLE) && (st != S_DONE);
  assign idx_ok        = (st == S_DONE);
  assign reg_dec       = (st == S_CALC) && (kind == K_DEC);
  assign reg_inc       = (st == S_DONE) && (kind == K_INC) && !bad_q;

`ifdef JT900H_IDXADDR_CHK_EN
  assign bad = idx_ok & bad_q;
`endif

  logic unused;
  assign unused = ^{rdreg_base[31:24], rdreg_aux[31:24], gmode[7]};

endmodule

// File: tb/tb_jt900h_idxaddr.sv
// Bench for jt900h_idxaddr: register-file model plus an expected-address
// scoreboard popped on every idx_ok pulse.
module tb_jt900h_idxaddr;
  logic        clk, rst, cen, start, fbyte_ok;
  logic [7:0]  mode_byte, fbyte;
  logic        fetch, reg_inc, reg_dec, busy, idx_ok;
  logic [7:0]  idx_rdreg_sel, idx_rdreg_aux;
  logic [1:0]  reg_step, opsize;
  logic [31:0] rdreg_base, rdreg_aux;
  logic [23:0] idx_addr;
`ifdef JT900H_IDXADDR_CHK_EN
  logic        bad;
`endif

  jt900h_idxaddr dut (
    .clk(clk), .rst(rst), .cen(cen), .start(start), .mode_byte(mode_byte),
    .fetch(fetch), .fbyte(fbyte), .fbyte_ok(fbyte_ok),
    .idx_rdreg_sel(idx_rdreg_sel), .idx_rdreg_aux(idx_rdreg_aux),
    .reg_step(reg_step), .reg_inc(reg_inc), .reg_dec(reg_dec),
    .rdreg_base(rdreg_base), .rdreg_aux(rdreg_aux), .busy(busy),
    .idx_addr(idx_addr), .idx_ok(idx_ok), .opsize(opsize)
`ifdef JT900H_IDXADDR_CHK_EN
    , .bad(bad)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [23:0] addr;
    logic [1:0]  opsz;
    logic        bad;
  } exp_t;
  exp_t sb_q[$];

  int n_tests = 0, n_fail = 0, n_ok = 0;
  int n_inc = 0, n_dec = 0;
  logic [7:0]  last_inc_aux;
  logic [1:0]  last_step;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] stepb(input logic [1:0] s);
    case (s)
      2'd1: return 32'd2;
      2'd2: return 32'd4;
      default: return 32'd1;
    endcase
  endfunction

  // Register file model, indexed by long register code
  logic [31:0] regs [0:255];
  logic        ld_en = 1'b0;
  logic [7:0]  ld_code;
  logic [31:0] ld_val;
  assign rdreg_base = regs[idx_rdreg_sel & 8'hFC];
  assign rdreg_aux  = regs[idx_rdreg_aux & 8'hFC] - (reg_dec ? stepb(reg_step) : 32'd0);

  always @(posedge clk) begin
    if (ld_en) regs[ld_code] <= ld_val;
    else if (!rst && cen) begin
      if (reg_inc) begin
        regs[idx_rdreg_aux & 8'hFC] <= regs[idx_rdreg_aux & 8'hFC] + stepb(reg_step);
        n_inc <= n_inc + 1;
        last_inc_aux <= idx_rdreg_aux;
      end
      if (reg_dec) begin
        regs[idx_rdreg_aux & 8'hFC] <= regs[idx_rdreg_aux & 8'hFC] - stepb(reg_step);
        n_dec <= n_dec + 1;
      end
    end
  end

  // Output monitor: pop the scoreboard on each completed operand
  always @(negedge clk) begin
    if (!rst) begin
      if (reg_inc && reg_dec) chk("inc_dec_both", 1, 0);
      if (idx_ok) begin
        n_ok++;
        last_step = reg_step;
        if (sb_q.size() == 0) chk("sb_empty", 1, 0);
        else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("idx_addr", {8'h0, idx_addr}, {8'h0, e.addr});
          chk("opsize", {30'h0, opsize}, {30'h0, e.opsz});
`ifdef JT900H_IDXADDR_CHK_EN
          chk("bad", {31'h0, bad}, {31'h0, e.bad});
`endif
        end
      end
    end
  end

  task automatic setreg(input logic [7:0] code, input logic [31:0] val);
    ld_en = 1'b1; ld_code = code; ld_val = val;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  task automatic push_exp(input logic [23:0] a, input logic [1:0] sz, input logic b);
    exp_t e;
    e.addr = a; e.opsz = sz; e.bad = b;
    sb_q.push_back(e);
  endtask

  // One operand: start, feed nb bytes (optional gap before the 2nd byte),
  // then wait for the idx_ok pulse. Entered and left at posedge+1.
  task automatic run_op(input logic [7:0] m, input int nb, input logic [23:0] bytes,
                        input int gap, input logic [23:0] ea, input logic [1:0] esz,
                        input logic eb);
    int t, ok0, extra;
    push_exp(ea, esz, eb);
    ok0 = n_ok;
    start = 1'b1; mode_byte = m;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < nb; i++) begin
      if (i == 1 && gap > 0) begin
        repeat (gap) begin @(posedge clk); #1; end
        chk("hold_fetch", {31'h0, fetch}, 1);
        chk("hold_busy", {31'h0, busy}, 1);
      end
      t = 0;
      while (!fetch && t < 20) begin @(posedge clk); #1; t++; end
      if (!fetch) chk("fetch_tmo", 0, 1);
      fbyte = bytes[8*i +: 8]; fbyte_ok = 1'b1;
      @(posedge clk); #1;
      fbyte_ok = 1'b0;
    end
    t = 0; extra = 0;
    while (n_ok == ok0 && t < 20) begin
      if (fetch) extra++;
      @(posedge clk); #1; t++;
    end
    chk("done", n_ok - ok0, 1);
    chk("extra_fetch", extra, 0);
  endtask

  initial begin
    int i0, d0, ok0, t;
    rst = 1'b1; cen = 1'b1; start = 1'b0; mode_byte = 8'h00;
    fbyte = 8'h00; fbyte_ok = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'h0, busy}, 0);
    chk("rst_ok", {31'h0, idx_ok}, 0);
    chk("rst_fetch", {31'h0, fetch}, 0);
    chk("rst_incdec", {30'h0, reg_inc, reg_dec}, 0);
    chk("rst_addr", {8'h0, idx_addr}, 0);
    chk("rst_sel", {16'h0, idx_rdreg_sel, idx_rdreg_aux}, 0);
    chk("rst_opsize", {30'h0, opsize}, 0);
    rst = 1'b0;

    // cen low: start must not be taken
    cen = 1'b0; start = 1'b1; mode_byte = 8'h84;
    repeat (2) begin @(posedge clk); #1; end
    chk("cen_hold", {31'h0, busy | idx_ok}, 0);
    start = 1'b0; cen = 1'b1;

    // (r+d8), negative displacement
    setreg(8'hF0, 32'h00123456);
    run_op(8'h8C, 1, 24'h0000FE, 0, 24'h123454, 2'd0, 1'b0);
    // #24 with a stall before the second byte
    run_op(8'hD2, 3, 24'h123456, 5, 24'h123456, 2'd1, 1'b0);

    // (r+) step 2 bytes
    i0 = n_inc; d0 = n_dec;
    run_op(8'hD5, 1, 24'h0000F1, 0, 24'h123456, 2'd1, 1'b0);
    @(posedge clk); #1;
    chk("inc_step", {30'h0, last_step}, 1);
    chk("inc_cnt", n_inc - i0, 1);
    chk("inc_nodec", n_dec - d0, 0);
    chk("inc_aux", {24'h0, last_inc_aux}, 32'hF0);
    chk("inc_xix", regs[8'hF0], 32'h00123458);

    // (-r) step 4 bytes
    setreg(8'hF0, 32'h00123456);
    i0 = n_inc; d0 = n_dec;
    run_op(8'hC4, 1, 24'h0000F2, 0, 24'h123452, 2'd0, 1'b0);
    chk("dec_cnt", n_dec - d0, 1);
    chk("dec_noinc", n_inc - i0, 0);
    chk("dec_xix", regs[8'hF0], 32'h00123452);

    // (r+r8) wrapping past 0xFFFFFF
    setreg(8'hF0, 32'h00FFFFF0);
    setreg(8'hE0, 32'h00000020);
    run_op(8'hC3, 3, 24'hE0F003, 0, 24'h000010, 2'd0, 1'b0);
    // (r+r16) negative index
    setreg(8'hF4, 32'h00001000);
    setreg(8'hE4, 32'h0000FFF0);
    run_op(8'hC3, 3, 24'hE4F407, 0, 24'h000FF0, 2'd0, 1'b0);
    // long-register (r) and (r+d16)
    run_op(8'hC3, 1, 24'h0000F4, 0, 24'h001000, 2'd0, 1'b0);
    setreg(8'hF0, 32'h00010000);
    run_op(8'hF3, 3, 24'h8000F1, 0, 24'h008000, 2'd3, 1'b0);

    // (r): top byte of the register ignored; address held afterwards
    setreg(8'hF8, 32'hAB654321);
    run_op(8'h86, 0, 24'h0, 0, 24'h654321, 2'd0, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    chk("addr_hold", {8'h0, idx_addr}, 32'h00654321);

    // (r+d8) wrap to zero, absolute forms zero-extended
    setreg(8'hEC, 32'h00FFFFFF);
    run_op(8'h8B, 1, 24'h000001, 0, 24'h000000, 2'd0, 1'b0);
    run_op(8'hC0, 1, 24'h000080, 0, 24'h000080, 2'd0, 1'b0);
    run_op(8'hE1, 2, 24'h00FFFF, 0, 24'h00FFFF, 2'd2, 1'b0);

`ifndef JT900H_IDXADDR_CHK_EN
    // step code 3 behaves as 1
    setreg(8'hF0, 32'h00000100);
    run_op(8'hD5, 1, 24'h0000F3, 0, 24'h000100, 2'd1, 1'b0);
    @(posedge clk); #1;
    chk("step3", {30'h0, last_step}, 1);
    chk("step3_xix", regs[8'hF0], 32'h00000102);
`else
    i0 = n_inc;
    run_op(8'hC7, 0, 24'h0, 0, 24'h000000, 2'd0, 1'b1);
    run_op(8'hD5, 1, 24'h0000F3, 0, 24'h000000, 2'd1, 1'b1);
    chk("abort_noinc", n_inc - i0, 0);
`endif

    // start coincident with DONE is taken afterwards
    setreg(8'hF0, 32'h00002222);
    push_exp(24'h002222, 2'd0, 1'b0);
    push_exp(24'h001000, 2'd0, 1'b0);
    ok0 = n_ok;
    start = 1'b1; mode_byte = 8'h84;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    chk("b2b_in_done", {31'h0, idx_ok}, 1);
    start = 1'b1; mode_byte = 8'h85;
    @(posedge clk); #1; start = 1'b0;
    t = 0;
    while (n_ok - ok0 < 2 && t < 20) begin @(posedge clk); #1; t++; end
    chk("b2b_done", n_ok - ok0, 2);

    // reset while (r+) waits in REG
    setreg(8'hF0, 32'h00123456);
    i0 = n_inc;
    start = 1'b1; mode_byte = 8'hD5;
    @(posedge clk); #1; start = 1'b0;
    chk("pre_rst_busy", {31'h0, busy}, 1);
    rst = 1'b1; #1;
    chk("mid_rst_busy", {31'h0, busy}, 0);
    chk("mid_rst_ok", {31'h0, idx_ok}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("mid_rst_noinc", n_inc - i0, 0);
    chk("mid_rst_xix", regs[8'hF0], 32'h00123456);
    chk("sb_left", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/jt900h_idxaddr.md
Name: jt900h_idxaddr

Overview:
Indexed memory addresser for the TLCS-900H core. It sits directly upstream of the register file. It decodes the memory-operand addressing byte, fetches extra operand bytes (displacements, absolute addresses, register codes) from the instruction stream, and drives the register file's read selectors and step/inc/dec controls. From the values returned it forms the 24-bit effective address consumed by the bus unit.

Parameters:
None. Address width is fixed at 24 bits; register values are 32 bits.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active high
cen  in  1  clock enable; all state advances only when cen=1
start  in  1  begin decode of mode_byte; ignored while busy=1
mode_byte  in  8  first operand byte, format 1 1/0 zz xxxx (0x80–0xF5)
fetch  out  1  request for the next instruction-stream byte
fbyte  in  8  instruction-stream byte
fbyte_ok  in  1  fbyte valid; consumed on the same cen cycle
idx_rdreg_sel  out  8  register-file base selector (long register code)
idx_rdreg_aux  out  8  register-file auxiliary selector
reg_step  out  2  0:1, 1:2, 2:4 bytes
reg_inc  out  1  post-increment write strobe to register file
reg_dec  out  1  pre-decrement strobe to register file
rdreg_base  in  32  register-file value addressed by idx_rdreg_sel
rdreg_aux  in  32  register-file value addressed by idx_rdreg_aux; already decremented when reg_dec=1
busy  out  1  decode in progress
idx_addr  out  24  effective address, valid while idx_ok=1
idx_ok  out  1  one cen-cycle pulse, address ready
opsize  out  2  mode_byte[5:4] latched at start

Behaviour:
- Reset (asynchronous): state IDLE. All outputs 0, except selectors, which reset to 8'h00.
- Short register mapping, rrr to long code: rrr<4 gives {4'hE, rrr[1:0], 2'b00}; rrr>=4 gives {4'hF, rrr[1:0], 2'b00}.
- FSM states:
  - IDLE: on start, latch mode_byte and opsize, set busy, then decode.
  - 10zz0rrr, (r): go to CALC.
  - 10zz1rrr, (r+d8): fetch 1 byte, then CALC.
  - 11zz0000, (#8): fetch 1 byte.
  - 11zz0001, (#16): fetch 2 bytes.
  - 11zz0010, (#24): fetch 3 bytes.
  - 11zz0011, long-register form: go to SUB.
  - 11zz0100, (-r): go to REG.
  - 11zz0101, (r+): go to REG.
  - SUB: fetch 1 byte s.
    - s[1:0]=00: (r), sel=s&FC.
    - s[1:0]=01: (r+d16).
    - s=03 or s=07: fetch base code, then index code, giving (r+r8) or (r+r16).
  - REG: fetch 1 byte g. sel=aux=g&FC, reg_step=g[1:0].
  - DISP: collects bytes, little-endian, one per fbyte_ok.
  - CALC: one cycle with selectors stable, then DONE.
  - DONE: idx_ok=1 for one cen cycle, busy drops, return to IDLE.
- fetch is high in every state that needs a byte. Stalling is unlimited: without fbyte_ok the state holds.
- Arithmetic: d8 and d16 are sign-extended to 24 bits. r8 and r16 index values are sign-extended. Sums are modulo 2^24, so 0xFFFFFF+1 gives 0x000000. Absolute #8/#16 are zero-extended.
- (-r): reg_dec=1 during CALC only; idx_addr=rdreg_aux[23:0] (the decremented value).
- (r+): idx_addr=rdreg_base[23:0]; reg_inc=1 for exactly one cen cycle in DONE, aux=sel.
- reg_inc and reg_dec are never both high. Each pulses at most once per operand.
- reg_step=3 is treated as 1.
- idx_addr is held from DONE until the next start.
- start coincident with DONE is accepted on the following cen cycle.
- Reset mid-operation aborts with no inc/dec pulse issued.

Optional Feature:
JT900H_IDXADDR_CHK_EN
- Defined: adds output bad (1 bit).
  - Reserved modes 11zz0110/0111/1xxx, SUB bytes other than the listed values, and REG step 3 all abort.
  - On abort: go to DONE with idx_ok=1, bad=1, idx_addr=0, no inc/dec.
- Undefined: no bad port; reserved modes decode as (#8) and step 3 uses 1.

Test Plan:
1. XIX=0x00123456, mode 0x8C, fbyte 0xFE -> one fetch, idx_addr=0x123454, idx_ok pulse, opsize=0.
2. mode 0xD2, bytes 0x56,0x34,0x12 with a 5-cycle gap before byte 2 -> three fetches, FSM holds, idx_addr=0x123456, opsize=1.
3. mode 0xD5, byte 0xF1, XIX=0x123456 -> idx_addr=0x123456, reg_step=1, single reg_inc with aux=0xF0, then XIX reads 0x123458.
4. mode 0xC4, byte 0xF2, XIX=0x123456 -> reg_dec during CALC, idx_addr=0x123452, XIX becomes 0x123452, no reg_inc.
5. mode 0xC3, bytes 0x03,0xF0,0xE0 with XIX=0xFFFFF0, A=0x20 -> idx_addr=0x000010 (wrap after sign-extend of +0x20).
6. Assert rst while mode 0xD5 is in REG -> busy=0, idx_ok=0, no reg_inc; CHK_EN build: mode 0xC7 -> bad=1, idx_addr=0.
